// File: rtl/pipe_writeback_pkg.sv
// Shared types and sizes for the writeback stage and its register file.
package pipe_writeback_pkg;

  localparam int WB_WIDTH  = 16;
  localparam int REG_AW    = 3;
  localparam int REG_COUNT = 8;
  localparam int CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_MEM    = 2'd1,
    SRC_PCINCR = 2'd2
  } wb_src_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_regfile.sv
// 8-entry register file: one write port, two combinational read ports with
// write-before-read bypass, asynchronous active-low clear.
module wb_regfile
  import pipe_writeback_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [WIDTH-1:0]  rdata1_o,
  output logic [WIDTH-1:0]  rdata2_o
);

  logic [WIDTH-1:0] regs_q [REG_COUNT];

  // NOTE: the array sits in the reset branch because every register must read
  // zero straight out of reset; that forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A commit to the same address shows up in decode in the same cycle.
  assign rdata1_o = (we_i && raddr1_i == waddr_i) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && raddr2_i == waddr_i) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/pipe_writeback.sv
// Writeback stage: source select, commit gating, sticky halt and a count of
// committed register writes, in front of a bypassed register file.
module pipe_writeback
  import pipe_writeback_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     wb_mem_out,
  input  logic [WIDTH-1:0]     wb_ALU_out,
  input  logic [WIDTH-1:0]     wb_PC_incr,
  input  logic                 wb_memtoreg,
  input  logic                 wb_regwrite,
  input  logic                 wb_jumpl,
  input  logic                 wb_halt,
  input  logic [REG_AW-1:0]    wb_writereg,
  input  logic [REG_AW-1:0]    rd_addr1,
  input  logic [REG_AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0]     rd_data1,
  output logic [WIDTH-1:0]     rd_data2,
  output logic [WIDTH-1:0]     wr_data,
  output logic                 fwd_valid,
  output logic [REG_AW-1:0]    fwd_reg,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] wr_count
);

  wb_src_e              src;
  wb_state_e            state_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 commit;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src = SRC_ALU;
    if (wb_jumpl)         src = SRC_PCINCR;
    else if (wb_memtoreg) src = SRC_MEM;
  end

  always_comb begin
    wr_data = wb_ALU_out;
    case (src)
      SRC_MEM:    wr_data = wb_mem_out;
      SRC_PCINCR: wr_data = wb_PC_incr;
      default:    wr_data = wb_ALU_out;
    endcase
  end

  // A halting instruction never writes, even if it also carries regwrite.
  assign commit    = en & wb_regwrite & (state_q == ST_RUN) & ~wb_halt;
  assign fwd_valid = commit;
  assign fwd_reg   = wb_writereg;
  assign halted    = (state_q == ST_HALTED);
  assign wr_count  = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
    end else if (en) begin
      case (state_q)
        ST_RUN:    if (wb_halt) state_q <= ST_HALTED;
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
      if (commit) count_q <= count_q + 1'b1;
    end
  end

  wb_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (commit),
    .waddr_i  (wb_writereg),
    .wdata_i  (wr_data),
    .raddr1_i (rd_addr1),
    .raddr2_i (rd_addr2),
    .rdata1_o (rd_data1),
    .rdata2_o (rd_data2)
  );

endmodule

// File: tb/tb_pipe_writeback.sv
// Self-checking bench for pipe_writeback: vector table, scoreboard of commits,
// hand sequences for halt, reset and counter wrap.
module tb_pipe_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] wb_mem_out, wb_ALU_out, wb_PC_incr;
  logic        wb_memtoreg, wb_regwrite, wb_jumpl, wb_halt;
  logic [2:0]  wb_writereg, rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2, wr_data;
  logic        fwd_valid;
  logic [2:0]  fwd_reg;
  logic        halted;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  pipe_writeback #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wb_mem_out(wb_mem_out), .wb_ALU_out(wb_ALU_out), .wb_PC_incr(wb_PC_incr),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_jumpl(wb_jumpl),
    .wb_halt(wb_halt), .wb_writereg(wb_writereg),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_data(wr_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .halted(halted), .wr_count(wr_count)
  );

  typedef struct {
    logic        en, rw, mt, jl;
    logic [2:0]  wr;
    logic [15:0] alu, mem, pc;
    logic [15:0] exp_wd;
    logic        exp_fv;
  } vec_t;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] v;
  } sb_t;

  vec_t        vecs [7];
  sb_t         sb [$];
  sb_t         ent;
  logic [15:0] model [8];
  logic [15:0] model_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic rw, input logic mt, input logic jl,
                       input logic h, input logic [2:0] wr,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc);
    en = e; wb_regwrite = rw; wb_memtoreg = mt; wb_jumpl = jl; wb_halt = h;
    wb_writereg = wr; wb_ALU_out = alu; wb_mem_out = mem; wb_PC_incr = pc;
  endtask

  task automatic check_all_regs(input string name);
    for (int r = 0; r < 8; r++) begin
      rd_addr1 = 3'(r);
      #1 check(name, rd_data1, model[r]);
    end
  endtask

  initial begin
    //            en  rw  mt  jl  wr  alu       mem       pc        exp_wd    fv
    vecs[0] = '{1'b1,1'b1,1'b0,1'b0,3'd3,16'h1234,16'h0000,16'h0000,16'h1234,1'b1};
    vecs[1] = '{1'b1,1'b1,1'b1,1'b0,3'd5,16'h1111,16'hBEEF,16'h0000,16'hBEEF,1'b1};
    vecs[2] = '{1'b1,1'b1,1'b1,1'b1,3'd7,16'h6666,16'h5555,16'h0042,16'h0042,1'b1};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b0,3'd2,16'hFFFF,16'h0000,16'h0000,16'hFFFF,1'b0};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b0,3'd4,16'hABCD,16'h0000,16'h0000,16'hABCD,1'b0};
    vecs[5] = '{1'b1,1'b1,1'b0,1'b0,3'd0,16'h0A0A,16'h0000,16'h0000,16'h0A0A,1'b1};
    vecs[6] = '{1'b1,1'b1,1'b0,1'b1,3'd3,16'h0000,16'h0000,16'h0100,16'h0100,1'b1};
    for (int r = 0; r < 8; r++) model[r] = '0;
    model_cnt = '0;

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
    rd_addr1 = '0; rd_addr2 = '0;
    #2;
    check("reset_halted", halted, 1'b0);
    check("reset_count", wr_count, 16'h0000);
    check_all_regs("reset_regs");
    @(negedge clk) rst = 1'b1;

    // Table-driven main function
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].rw, vecs[i].mt, vecs[i].jl, 1'b0, vecs[i].wr,
            vecs[i].alu, vecs[i].mem, vecs[i].pc);
      rd_addr1 = vecs[i].wr + 3'd1;
      rd_addr2 = vecs[i].wr;
      #1;
      check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].exp_wd);
      check($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].exp_fv);
      check($sformatf("v%0d_fwd_reg", i), fwd_reg, vecs[i].wr);
      check($sformatf("v%0d_rd2_bypass", i), rd_data2,
            vecs[i].exp_fv ? vecs[i].exp_wd : model[vecs[i].wr]);
      check($sformatf("v%0d_rd1_other", i), rd_data1, model[vecs[i].wr + 3'd1]);
      if (vecs[i].exp_fv) begin
        sb.push_back('{vecs[i].wr, vecs[i].exp_wd});
        model[vecs[i].wr] = vecs[i].exp_wd;
        model_cnt++;
      end
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        rd_addr1 = ent.r;
        #1 check($sformatf("v%0d_committed", i), rd_data1, ent.v);
      end else begin
        rd_addr1 = vecs[i].wr;
        #1 check($sformatf("v%0d_unchanged", i), rd_data1, model[vecs[i].wr]);
      end
      check($sformatf("v%0d_count", i), wr_count, model_cnt);
    end
    check("sb_empty", sb.size(), 0);

    // Halt with en low must not set halted
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h7777, '0, '0);
    @(posedge clk); #1;
    check("halt_stalled", halted, 1'b0);

    // Halting instruction with regwrite must not write
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h7777, '0, '0);
    #1 check("halt_instr_fwd", fwd_valid, 1'b0);
    @(posedge clk); #1;
    check("halted_set", halted, 1'b1);
    rd_addr1 = 3'd1;
    #1 check("halt_r1_unchanged", rd_data1, model[1]);

    // Later writes ignored while halted; reads still work
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h8888, '0, '0);
    #1 check("halted_fwd", fwd_valid, 1'b0);
    @(posedge clk); #1;
    check("halted_sticky", halted, 1'b1);
    check("halted_count", wr_count, model_cnt);
    check_all_regs("halted_regs");

    // Reset clears everything and beats a commit presented during reset
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
    #2 rst = 1'b0;
    for (int r = 0; r < 8; r++) model[r] = '0;
    model_cnt = '0;
    #1;
    check("rst_halted", halted, 1'b0);
    check("rst_count", wr_count, 16'h0000);
    check_all_regs("rst_regs");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 16'h5A5A, '0, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
    rd_addr1 = 3'd6;
    #1 check("rst_wins_r6", rd_data1, 16'h0000);
    check("rst_wins_count", wr_count, 16'h0000);
    @(negedge clk) rst = 1'b1;

    // Counter wrap: 65535 commits then one more
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0000, '0, '0);
    for (int n = 0; n < 65535; n++) begin
      wb_ALU_out = 16'(n);
      @(posedge clk); #1;
    end
    model[4] = 16'hFFFE;
    check("cnt_ffff", wr_count, 16'hFFFF);
    rd_addr1 = 3'd4;
    #1 check("cnt_r4_last", rd_data1, model[4]);
    @(posedge clk); #1;
    check("cnt_wrap", wr_count, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
